decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/decode_stage_if.sv | 29 ++
 rtl/regfile_2r1w.sv | 37 +++
 rtl/decode_stage.sv | 102 ++++++++++
 tb/tb_decode_stage.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, immediate formats and instruction field positions
package cpu_pkg;

  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [6:0]  OP_CB   = 7'b1011010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  localparam int RT_LO = 0;
  localparam int RT_HI = 4;
  localparam int RN_LO = 5;
  localparam int RN_HI = 9;
  localparam int RM_LO = 16;
  localparam int RM_HI = 20;

  localparam int B_IMM_HI  = 25;
  localparam int CB_IMM_LO = 5;
  localparam int CB_IMM_HI = 23;
  localparam int D_IMM_LO  = 12;
  localparam int D_IMM_HI  = 20;

  typedef enum logic [1:0] {
    IMM_D,
    IMM_B,
    IMM_CB
  } imm_sel_e;

  function automatic imm_sel_e imm_sel_of(input logic [31:0] instr);
    if (instr[31:26] == OP_B) return IMM_B;
    if (instr[31:25] == OP_CB) return IMM_CB;
    return IMM_D;
  endfunction

  // Stores and compare-branches carry their second source in the Rt slot
  function automatic logic reg2loc_of(input logic [31:0] instr);
    return (instr[31:21] == OP_STUR) || (instr[31:25] == OP_CB);
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-side and execute-side handshakes of the decode stage
interface decode_stage_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_rd1;
  logic [XLEN-1:0] out_rd2;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_rd1, out_rd2, out_imm, out_rs1, out_rs2
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_rd1, out_rd2, out_imm, out_rs1, out_rs2
  );
endinterface

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - register file, two async reads with writeback bypass, one sync write
module regfile_2r1w #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int ZREG  = 31
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);
  localparam logic [5:0] NREGS_W = 6'(NREGS);
  localparam logic [4:0] ZREG_W  = 5'(ZREG);

  logic [XLEN-1:0] mem [NREGS];

  // Zero register and unimplemented indices never hold state
  function automatic logic live(input logic [4:0] a);
    return (a != ZREG_W) && ({1'b0, a} < NREGS_W);
  endfunction

  assign rd1 = !live(ra1) ? '0 : (we && (wa == ra1)) ? wd : mem[ra1];
  assign rd2 = !live(ra2) ? '0 : (we && (wa == ra2)) ? wd : mem[ra2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && live(wa)) begin
      mem[wa] <= wd;
    end
  end
endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - decode: operand read, immediate generation, load-use stall, output register
module decode_stage
  import cpu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int ZREG  = 31
) (
  input  logic            clk,
  input  logic            rst_n,
  decode_stage_if.slave   bus,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_memread,
  input  logic [4:0]      ex_rd
);
  localparam logic [4:0] ZREG_W = 5'(ZREG);

  logic [31:0]     instr;
  logic [4:0]      rs1, rs2;
  logic [XLEN-1:0] rd1, rd2, imm;
  imm_sel_e        sel;
  logic            hazard, in_ready, xfer;

  logic            out_valid_q;
  logic [XLEN-1:0] pc_q, rd1_q, rd2_q, imm_q;
  logic [31:0]     instr_q;
  logic [4:0]      rs1_q, rs2_q;

  assign instr = bus.in_instr;
  assign rs1   = instr[RN_HI:RN_LO];
  assign rs2   = reg2loc_of(instr) ? instr[RT_HI:RT_LO] : instr[RM_HI:RM_LO];
  assign sel   = imm_sel_of(instr);

  always_comb begin
    imm = '0;
    case (sel)
      IMM_B:   imm = {{(XLEN - B_IMM_HI - 1){instr[B_IMM_HI]}}, instr[B_IMM_HI:0]};
      IMM_CB:  imm = {{(XLEN - (CB_IMM_HI - CB_IMM_LO + 1)){instr[CB_IMM_HI]}},
                      instr[CB_IMM_HI:CB_IMM_LO]};
      default: imm = {{(XLEN - (D_IMM_HI - D_IMM_LO + 1)){instr[D_IMM_HI]}},
                      instr[D_IMM_HI:D_IMM_LO]};
    endcase
  end

  regfile_2r1w #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .ZREG  (ZREG)
  ) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs1),
    .ra2   (rs2),
    .rd1   (rd1),
    .rd2   (rd2),
    .we    (wb_en),
    .wa    (wb_addr),
    .wd    (wb_data)
  );

  // A load in execute cannot forward in time; stall its consumers one cycle
  assign hazard   = bus.in_valid & ex_memread & (ex_rd != ZREG_W) &
                    ((ex_rd == rs1) | (ex_rd == rs2));
  assign in_ready = rst_n & ~hazard & (~out_valid_q | bus.out_ready);
  assign xfer     = bus.in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      instr_q     <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      pc_q        <= bus.in_pc;
      instr_q     <= instr;
      rd1_q       <= rd1;
      rd2_q       <= rd2;
      imm_q       <= imm;
      rs1_q       <= rs1;
      rs2_q       <= rs2;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pc    = pc_q;
  assign bus.out_instr = instr_q;
  assign bus.out_rd1   = rd1_q;
  assign bus.out_rd2   = rd2_q;
  assign bus.out_imm   = imm_q;
  assign bus.out_rs1   = rs1_q;
  assign bus.out_rs2   = rs2_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - decode_stage against a behavioural model, directed plus random stimulus
module tb_decode_stage;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, out_ready, wb_en, ex_memread;
  logic [31:0] in_instr;
  logic [63:0] in_pc, wb_data;
  logic [4:0]  wb_addr, ex_rd;
  logic        in_ready, out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc, out_rd1, out_rd2, out_imm;
  logic [4:0]  out_rs1, out_rs2;

  decode_stage_if #(.XLEN(XLEN)) bus ();

  assign bus.in_valid  = in_valid;
  assign bus.in_instr  = in_instr;
  assign bus.in_pc     = in_pc;
  assign bus.out_ready = out_ready;
  assign in_ready      = bus.in_ready;
  assign out_valid     = bus.out_valid;
  assign out_pc        = bus.out_pc;
  assign out_instr     = bus.out_instr;
  assign out_rd1       = bus.out_rd1;
  assign out_rd2       = bus.out_rd2;
  assign out_imm       = bus.out_imm;
  assign out_rs1       = bus.out_rs1;
  assign out_rs2       = bus.out_rs2;

  decode_stage #(.XLEN(XLEN), .NREGS(32), .ZREG(31)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit is_b(logic [31:0] i);    return i[31:26] == 6'h05;   endfunction
  function automatic bit is_cb(logic [31:0] i);   return i[31:25] == 7'h5A;   endfunction
  function automatic bit is_stur(logic [31:0] i); return i[31:21] == 11'h7C0; endfunction
  function automatic logic [4:0] src1(logic [31:0] i); return i[9:5]; endfunction
  function automatic logic [4:0] src2(logic [31:0] i);
    return (is_stur(i) || is_cb(i)) ? i[4:0] : i[20:16];
  endfunction

  function automatic longint sext(longint v, int bits);
    if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
    return v;
  endfunction

  function automatic logic [63:0] immed(logic [31:0] i);
    if (is_b(i))  return sext(longint'(i[25:0]), 26);
    if (is_cb(i)) return sext(longint'(i[23:5]), 19);
    return sext(longint'(i[20:12]), 9);
  endfunction

  logic [63:0] m_rf [32];
  bit          m_valid;
  logic [63:0] m_pc, m_rd1, m_rd2, m_imm;
  logic [31:0] m_instr;
  logic [4:0]  m_rs1, m_rs2;

  function automatic logic [63:0] m_read(logic [4:0] idx);
    if (idx == 5'd31) return 64'd0;
    if (wb_en && wb_addr == idx) return wb_data;
    return m_rf[idx];
  endfunction

  function automatic bit m_in_ready();
    bit hz;
    hz = in_valid && ex_memread && ex_rd != 5'd31 &&
         (ex_rd == src1(in_instr) || ex_rd == src2(in_instr));
    return !hz && (!m_valid || out_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      foreach (m_rf[i]) m_rf[i] = 64'd0;
    end else begin
      if (in_valid && m_in_ready()) begin
        m_valid = 1'b1;
        m_pc    = in_pc;
        m_instr = in_instr;
        m_rs1   = src1(in_instr);
        m_rs2   = src2(in_instr);
        m_rd1   = m_read(m_rs1);
        m_rd2   = m_read(m_rs2);
        m_imm   = immed(in_instr);
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      if (wb_en && wb_addr != 5'd31) m_rf[wb_addr] = wb_data;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
    end else begin
      chk("in_ready", in_ready, m_in_ready());
      chk("out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("out_pc", out_pc, m_pc);
        chk("out_instr", out_instr, m_instr);
        chk("out_rd1", out_rd1, m_rd1);
        chk("out_rd2", out_rd2, m_rd2);
        chk("out_imm", out_imm, m_imm);
        chk("out_rs1", out_rs1, m_rs1);
        chk("out_rs2", out_rs2, m_rs2);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] add_i(logic [4:0] rd, logic [4:0] rn, logic [4:0] rm);
    return {11'b10001011000, rm, 6'b0, rn, rd};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    a = 5'($urandom);
    b = 5'($urandom);
    c = 5'($urandom);
    case ($urandom_range(0, 4))
      0: return add_i(a, b, c);
      1: return {11'h7C0, 9'($urandom), 2'b00, b, c};
      2: return {7'h5A, 1'($urandom), 19'($urandom), c};
      3: return {6'h05, 26'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] tmp_instr;

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; ex_memread = 1'b0; ex_rd = '0;

    tmp_instr = 32'h17FFFFFF;
    chk("model_imm_b", immed(tmp_instr), 64'hFFFF_FFFF_FFFF_FFFF);
    tmp_instr = 32'hB4000209;
    chk("model_imm_cb", immed(tmp_instr), 64'd16);
    chk("model_rs2_cb", 64'(src2(tmp_instr)), 64'd9);
    tmp_instr = {11'h7C0, 9'h1FF, 2'b00, 5'd2, 5'd3};
    chk("model_imm_d_neg", immed(tmp_instr), 64'hFFFF_FFFF_FFFF_FFFF);

    #1 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_rd1", out_rd1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk("post_reset_valid", out_valid, 0);

    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 64'h1234;
    tick();
    wb_en = 1'b0; in_valid = 1'b1; in_instr = add_i(5'd1, 5'd3, 5'd4); in_pc = 64'h100;
    tick();
    in_valid = 1'b0;
    chk("add_valid", out_valid, 1);
    chk("add_rd1", out_rd1, 64'h1234);
    chk("add_pc", out_pc, 64'h100);
    chk("add_imm", out_imm, 64'd64);

    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 64'hAA;
    in_valid = 1'b1; in_instr = add_i(5'd2, 5'd5, 5'd0);
    tick();
    wb_en = 1'b0; in_valid = 1'b0;
    chk("bypass_rd1", out_rd1, 64'hAA);

    in_valid = 1'b1; in_instr = 32'h17FFFFFF;
    tick();
    chk("b_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    in_instr = {8'hB4, 19'h10, 5'd9};
    tick();
    in_valid = 1'b0;
    chk("cbz_imm", out_imm, 64'd16);
    chk("cbz_rs2", out_rs2, 64'd9);

    ex_memread = 1'b1; ex_rd = 5'd7;
    in_valid = 1'b1; in_instr = add_i(5'd1, 5'd7, 5'd2);
    #1 chk("hazard_in_ready", in_ready, 0);
    tick();
    chk("hazard_bubble", out_valid, 0);
    ex_memread = 1'b0;
    #1 chk("hazard_cleared_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("hazard_accept_valid", out_valid, 1);
    chk("hazard_accept_instr", out_instr, 64'(add_i(5'd1, 5'd7, 5'd2)));

    in_valid = 1'b1; in_instr = add_i(5'd9, 5'd3, 5'd3);
    tick();
    out_ready = 1'b0; in_instr = add_i(5'd10, 5'd4, 5'd4);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_instr", out_instr, 64'(add_i(5'd9, 5'd3, 5'd3)));
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_instr = add_i(5'(k), 5'(k + 1), 5'd2);
      tick();
      chk("stream_instr", out_instr, 64'(add_i(5'(k), 5'(k + 1), 5'd2)));
      chk("stream_valid", out_valid, 1);
    end
    in_valid = 1'b0;

    wb_en = 1'b1; wb_addr = 5'd31; wb_data = 64'hFF;
    tick();
    in_valid = 1'b1; in_instr = add_i(5'd1, 5'd31, 5'd31);
    tick();
    wb_en = 1'b0; in_valid = 1'b0;
    chk("zreg_rd1", out_rd1, 0);
    chk("zreg_rd2", out_rd2, 0);

    in_valid = 1'b1; in_instr = add_i(5'd1, 5'd3, 5'd3);
    tick();
    chk("pre_reset_rd1", out_rd1, 64'h1234);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_valid", out_valid, 0);
    chk("async_reset_rd1", out_rd1, 0);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("after_reset_valid", out_valid, 1);
    chk("after_reset_x3", out_rd1, 0);

    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_pc     = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      wb_en     = 1'($urandom_range(0, 1));
      wb_addr   = ($urandom_range(0, 3) == 0) ? src1(in_instr) : 5'($urandom);
      wb_data   = {$urandom, $urandom};
      ex_memread = ($urandom_range(0, 3) == 0);
      ex_rd     = ($urandom_range(0, 1) != 0) ? src1(in_instr) : 5'($urandom);
      tick();
    end

    in_valid = 1'b0; wb_en = 1'b0; ex_memread = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
